// File: rtl/key_slot_bank_pkg.sv
// Shared constants, default slot geometry and zeroize FSM encoding for the DSA key store.
package key_slot_bank_pkg;

    localparam int unsigned WORD_W_DEF    = 32;
    localparam int unsigned NUM_SLOTS_DEF = 5;
    localparam int unsigned MAX_WORDS_DEF = 32;

    localparam int unsigned SLOT_PRIV = 0;
    localparam int unsigned SLOT_Q    = 1;
    localparam int unsigned SLOT_P    = 2;
    localparam int unsigned SLOT_G    = 3;
    localparam int unsigned SLOT_Y    = 4;

    // Slot s length lives in bits [8s +: 8]: priv=4, q=5, p/g/y=32 words.
    localparam logic [8*NUM_SLOTS_DEF-1:0] SLOT_LEN_DEF    = {8'd32, 8'd32, 8'd32, 8'd5, 8'd4};
    localparam logic [NUM_SLOTS_DEF-1:0]   SECRET_MASK_DEF = 5'b00001;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } zstate_e;

endpackage

// File: rtl/key_slot_bank_if.sv
// Host/core-facing bundle of the key store: write port, lock/zeroize control, readback, key bus.
interface key_slot_bank_if
    import key_slot_bank_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
    parameter int unsigned IDX_W     = $clog2(MAX_WORDS)
);
    logic                              wrValid;
    logic                              wrReady;
    logic [SLOT_W-1:0]                 wrSlot;
    logic [IDX_W-1:0]                  wrIndex;
    logic [WORD_W-1:0]                 wrData;
    logic                              wrError;
    logic [NUM_SLOTS-1:0]              lockSet;
    logic [NUM_SLOTS-1:0]              locked;
    logic [NUM_SLOTS-1:0]              slotValid;
    logic                              zeroizeReq;
    logic                              busy;
    logic                              rdEn;
    logic [SLOT_W-1:0]                 rdSlot;
    logic [IDX_W-1:0]                  rdIndex;
    logic [WORD_W-1:0]                 rdData;
    logic                              rdValid;
    logic [NUM_SLOTS*MAX_WORDS*WORD_W-1:0] keyFlat;

    modport slave (
        input  wrValid, wrSlot, wrIndex, wrData, lockSet, zeroizeReq, rdEn, rdSlot, rdIndex,
        output wrReady, wrError, locked, slotValid, busy, rdData, rdValid, keyFlat
    );

    modport master (
        output wrValid, wrSlot, wrIndex, wrData, lockSet, zeroizeReq, rdEn, rdSlot, rdIndex,
        input  wrReady, wrError, locked, slotValid, busy, rdData, rdValid, keyFlat
    );
endinterface

// File: rtl/key_slot_bank_slot.sv
// One key slot: word array, written-mask, completeness flag and write lock, with a clear-word port.
module key_slot
    import key_slot_bank_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned SLOT_LEN  = MAX_WORDS_DEF,
    localparam int unsigned IDX_W    = $clog2(MAX_WORDS)
) (
    input  logic                            clock,
    input  logic                            resetN,
    input  logic                            i_wr_en,
    input  logic [IDX_W-1:0]                i_wr_idx,
    input  logic [WORD_W-1:0]               i_wr_data,
    input  logic                            i_clr_en,
    input  logic [IDX_W-1:0]                i_clr_idx,
    input  logic                            i_clr_all,
    input  logic                            i_lock_set,
    output logic [MAX_WORDS-1:0][WORD_W-1:0] o_words,
    output logic                            o_valid,
    output logic                            o_locked
);
    logic [MAX_WORDS-1:0][WORD_W-1:0] r_mem;
    logic [MAX_WORDS-1:0]             r_mask;
    logic                             r_valid;
    logic                             r_locked;
    logic [MAX_WORDS-1:0]             w_mask_d;
    logic [MAX_WORDS-1:0]             w_need;

    always_comb begin
        w_need = '0;
        for (int i = 0; i < int'(MAX_WORDS); i++) begin
            w_need[i] = (i < int'(SLOT_LEN));
        end
    end

    always_comb begin
        w_mask_d = r_mask;
        if (i_wr_en) begin
            w_mask_d[i_wr_idx] = 1'b1;
        end
        if (i_clr_all) begin
            w_mask_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_mem    <= '0;
            r_mask   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_idx] <= i_wr_data;
            end
            if (i_clr_en) begin
                r_mem[i_clr_idx] <= '0;
            end
            r_mask <= w_mask_d;
            // Judged on the next mask so valid rises right after the final word lands.
            r_valid  <= !i_clr_all && ((w_mask_d & w_need) == w_need);
            r_locked <= i_clr_all ? 1'b0 : (r_locked | (i_lock_set & r_valid));
        end
    end

    assign o_words  = r_mem;
    assign o_valid  = r_valid;
    assign o_locked = r_locked;

endmodule

// File: rtl/key_slot_bank.sv
// DSA key store top: write decode/error, sequenced zeroize, masked readback and flat key bus.
module key_slot_bank
    import key_slot_bank_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter logic [8*NUM_SLOTS-1:0] SLOT_LEN    = SLOT_LEN_DEF,
    parameter logic [NUM_SLOTS-1:0]   SECRET_MASK = SECRET_MASK_DEF
) (
    input  logic           clock,
    input  logic           resetN,
    key_slot_bank_if.slave bus
);
    localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS);
    localparam int unsigned IDX_W   = $clog2(MAX_WORDS);
    localparam int unsigned SLICE_W = MAX_WORDS * WORD_W;

    zstate_e                          r_state;
    logic [SLOT_W-1:0]                r_clr_slot;
    logic [IDX_W-1:0]                 r_clr_idx;
    logic                             r_wr_error;
    logic                             r_rd_valid;
    logic [WORD_W-1:0]                r_rd_data;

    logic                             w_busy;
    logic                             w_wr_ready;
    logic                             w_wr_fire;
    logic                             w_wr_bad;
    logic                             w_rd_ok;
    logic [WORD_W-1:0]                w_rd_word;
    logic [NUM_SLOTS-1:0]             w_wr_en;
    logic [NUM_SLOTS-1:0]             w_clr_en;
    logic [NUM_SLOTS-1:0]             w_valid;
    logic [NUM_SLOTS-1:0]             w_locked;
    logic [NUM_SLOTS*SLICE_W-1:0]     w_key_flat;

    assign w_busy     = (r_state != StIdle);
    assign w_wr_ready = (r_state == StIdle) && !bus.zeroizeReq;
    assign w_wr_fire  = bus.wrValid && w_wr_ready;

    // Out-of-range slots fall through with w_wr_bad still set.
    always_comb begin
        w_wr_bad = 1'b1;
        w_wr_en  = '0;
        w_clr_en = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            if (int'(bus.wrSlot) == s) begin
                w_wr_bad = (int'(bus.wrIndex) >= int'(SLOT_LEN[8*s +: 8])) || w_locked[s];
            end
        end
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            w_wr_en[s]  = w_wr_fire && !w_wr_bad && (int'(bus.wrSlot) == s);
            w_clr_en[s] = (r_state == StClear) && (int'(r_clr_slot) == s);
        end
    end

    always_comb begin
        w_rd_ok   = 1'b0;
        w_rd_word = '0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            if ((int'(bus.rdSlot) == s) && (int'(bus.rdIndex) < int'(SLOT_LEN[8*s +: 8]))
                && !SECRET_MASK[s]) begin
                w_rd_ok   = 1'b1;
                w_rd_word = w_key_flat[(s*MAX_WORDS + int'(bus.rdIndex))*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state    <= StIdle;
            r_clr_slot <= '0;
            r_clr_idx  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.zeroizeReq) begin
                        r_state    <= StClear;
                        r_clr_slot <= '0;
                        r_clr_idx  <= '0;
                    end
                end
                StClear: begin
                    if (r_clr_idx == IDX_W'(MAX_WORDS - 1)) begin
                        r_clr_idx <= '0;
                        if (r_clr_slot == SLOT_W'(NUM_SLOTS - 1)) begin
                            r_clr_slot <= '0;
                            r_state    <= StDone;
                        end else begin
                            r_clr_slot <= r_clr_slot + SLOT_W'(1);
                        end
                    end else begin
                        r_clr_idx <= r_clr_idx + IDX_W'(1);
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_wr_error <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_error <= w_wr_fire && w_wr_bad;
            r_rd_valid <= bus.rdEn;
            if (bus.rdEn) begin
                r_rd_data <= (w_rd_ok && !w_busy) ? w_rd_word : '0;
            end
        end
    end

    for (genvar s = 0; s < int'(NUM_SLOTS); s++) begin : g_slot
        key_slot #(
            .WORD_W    (WORD_W),
            .MAX_WORDS (MAX_WORDS),
            .SLOT_LEN  (int'(SLOT_LEN[8*s +: 8]))
        ) u_slot (
            .clock      (clock),
            .resetN     (resetN),
            .i_wr_en    (w_wr_en[s]),
            .i_wr_idx   (bus.wrIndex),
            .i_wr_data  (bus.wrData),
            .i_clr_en   (w_clr_en[s]),
            .i_clr_idx  (r_clr_idx),
            .i_clr_all  (r_state == StDone),
            .i_lock_set (bus.lockSet[s]),
            .o_words    (w_key_flat[s*SLICE_W +: SLICE_W]),
            .o_valid    (w_valid[s]),
            .o_locked   (w_locked[s])
        );
    end

    assign bus.wrReady   = w_wr_ready;
    assign bus.wrError   = r_wr_error;
    assign bus.locked    = w_locked;
    assign bus.slotValid = w_valid;
    assign bus.busy      = w_busy;
    assign bus.rdData    = r_rd_data;
    assign bus.rdValid   = r_rd_valid;
    assign bus.keyFlat   = w_key_flat;

endmodule

// File: tb/tb_key_slot_bank.sv
// Directed bench for key_slot_bank: model of slot contents plus a readback scoreboard queue.
module tb_key_slot_bank;

    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    key_slot_bank_if bus ();

    key_slot_bank u_dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    int unsigned     n_tests = 0;
    int unsigned     n_fail  = 0;
    int unsigned     len_tbl [5] = '{4, 5, 32, 32, 32};
    logic [4:0]      secret      = 5'b00001;
    logic [31:0]     m_mem [5][32];
    logic [31:0]     m_mask [5];
    logic [4:0]      m_locked;
    logic            m_busy;
    logic [31:0]     sb [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] m_valid();
        logic [4:0] v;
        for (int s = 0; s < 5; s++) begin
            v[s] = 1'b1;
            for (int i = 0; i < int'(len_tbl[s]); i++) v[s] &= m_mask[s][i];
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 5; s++) begin
            m_mask[s] = '0;
            for (int i = 0; i < 32; i++) m_mem[s][i] = '0;
        end
        m_locked = '0;
        m_busy   = 1'b0;
    endtask

    task automatic check_flat(input string tag);
        logic [5119:0] exp;
        int            first;
        for (int s = 0; s < 5; s++)
            for (int i = 0; i < 32; i++) exp[(s*32+i)*32 +: 32] = m_mem[s][i];
        first = 0;
        for (int w = 159; w >= 0; w--)
            if (bus.keyFlat[w*32 +: 32] !== exp[w*32 +: 32]) first = w;
        n_tests++;
        assert (bus.keyFlat === exp) else begin
            n_fail++;
            $error("FAIL %s: word %0d observed %0h expected %0h", tag, first,
                   bus.keyFlat[first*32 +: 32], exp[first*32 +: 32]);
        end
    endtask

    task automatic wr(input int s, input int i, input logic [31:0] d);
        logic bad;
        bad = 1'b1;
        if (s < 5) bad = (i >= int'(len_tbl[s])) || m_locked[s];
        bus.wrValid = 1'b1;
        bus.wrSlot  = 3'(s);
        bus.wrIndex = 5'(i);
        bus.wrData  = d;
        tick();
        bus.wrValid = 1'b0;
        if (!bad) begin
            m_mem[s][i]  = d;
            m_mask[s][i] = 1'b1;
        end
        check($sformatf("wr_error s%0d i%0d", s, i), 128'(bus.wrError), 128'(bad));
        check($sformatf("slot_valid s%0d i%0d", s, i), 128'(bus.slotValid), 128'(m_valid()));
    endtask

    task automatic lock(input logic [4:0] req);
        logic [4:0] v;
        v = m_valid();
        bus.lockSet = req;
        tick();
        bus.lockSet = '0;
        m_locked |= req & v;
        check("locked", 128'(bus.locked), 128'(m_locked));
    endtask

    task automatic rd_push(input int s, input int i);
        logic [31:0] e;
        e = '0;
        if (s < 5 && !m_busy && !secret[s])
            if (i < int'(len_tbl[s])) e = m_mem[s][i];
        sb.push_back(e);
        bus.rdEn    = 1'b1;
        bus.rdSlot  = 3'(s);
        bus.rdIndex = 5'(i);
    endtask

    task automatic rd_pop(input string tag);
        int w;
        logic [31:0] e;
        w = 0;
        while (bus.rdValid !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, 128'(bus.rdValid), 128'(1'b1));
        e = sb.pop_front();
        check({tag, "_data"}, 128'(bus.rdData), 128'(e));
    endtask

    task automatic rd(input int s, input int i, input string tag);
        rd_push(s, i);
        tick();
        bus.rdEn = 1'b0;
        rd_pop(tag);
    endtask

    initial begin
        int n;
        bus.wrValid = 0; bus.wrSlot = 0; bus.wrIndex = 0; bus.wrData = 0;
        bus.lockSet = 0; bus.zeroizeReq = 0; bus.rdEn = 0; bus.rdSlot = 0; bus.rdIndex = 0;
        model_clear();
        resetN = 1'b1;
        #2 resetN = 1'b0;
        repeat (3) tick();
        check("rst_slot_valid", 128'(bus.slotValid), 128'(0));
        check("rst_locked", 128'(bus.locked), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_wr_error", 128'(bus.wrError), 128'(0));
        check("rst_rd_valid", 128'(bus.rdValid), 128'(0));
        check("rst_rd_data", 128'(bus.rdData), 128'(0));
        check_flat("rst_key_flat");
        resetN = 1'b1;
        tick();
        check("rst_wr_ready", 128'(bus.wrReady), 128'(1));

        // Load slot 0
        for (int i = 0; i < 4; i++) wr(0, i, 32'hC5F4B81A + 32'(i));
        check("load_valid0", 128'(bus.slotValid), 128'(5'b00001));
        check("load_flat_lo", bus.keyFlat[127:0],
              128'hC5F4B81D_C5F4B81C_C5F4B81B_C5F4B81A);

        // Out-of-range writes
        wr(1, 5, 32'h0BAD0BAD);
        check_flat("oor_idx_flat");
        tick();
        check("err_pulse_clear", 128'(bus.wrError), 128'(0));
        wr(5, 0, 32'h0BAD0BAD);
        check_flat("oor_slot_flat");

        // Locking
        lock(5'b00001);
        check("lock0", 128'(bus.locked), 128'(5'b00001));
        wr(0, 0, 32'hDEADBEEF);
        check("locked_word0", 128'(bus.keyFlat[31:0]), 128'(32'hC5F4B81A));
        lock(5'b00010);

        // Readback
        rd(0, 0, "rd_secret");
        wr(1, 2, 32'h12345678);
        rd(1, 2, "rd_s1i2");
        rd(1, 5, "rd_oor");
        rd(1, 0, "rd_unwritten");
        // Same-cycle write and read of one word returns the old value
        rd_push(1, 2);
        bus.wrValid = 1'b1; bus.wrSlot = 3'd1; bus.wrIndex = 5'd2; bus.wrData = 32'hAAAA5555;
        tick();
        bus.wrValid = 1'b0; bus.rdEn = 1'b0;
        m_mem[1][2] = 32'hAAAA5555; m_mask[1][2] = 1'b1;
        rd_pop("rd_same_cycle");
        rd(1, 2, "rd_after_wr");

        // Load everything, then zeroize
        for (int i = 0; i < 5; i++) wr(1, i, $urandom);
        for (int s = 2; s < 5; s++)
            for (int i = 0; i < 32; i++) wr(s, i, $urandom);
        check("all_valid", 128'(bus.slotValid), 128'(5'b11111));
        lock(5'b00100);
        check_flat("all_flat");
        bus.zeroizeReq = 1'b1;
        bus.wrValid = 1'b1; bus.wrSlot = 3'd1; bus.wrIndex = 5'd0; bus.wrData = 32'h5A5A5A5A;
        #1 check("zero_wr_ready", 128'(bus.wrReady), 128'(0));
        tick();
        bus.zeroizeReq = 1'b0; bus.wrValid = 1'b0;
        check("zero_no_wr_error", 128'(bus.wrError), 128'(0));
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            n++;
            if (n == 50) check("busy_wr_ready", 128'(bus.wrReady), 128'(0));
            tick();
        end
        check("busy_cycles", 128'(n), 128'(161));
        model_clear();
        check_flat("zero_flat");
        check("zero_valid", 128'(bus.slotValid), 128'(0));
        check("zero_locked", 128'(bus.locked), 128'(0));

        // Reset in the middle of zeroize
        for (int i = 0; i < 5; i++) wr(1, i, 32'h1000 + 32'(i));
        lock(5'b00010);
        bus.zeroizeReq = 1'b1;
        tick();
        bus.zeroizeReq = 1'b0;
        m_busy = 1'b1;
        repeat (19) tick();
        rd(1, 0, "rd_busy");
        repeat (19) tick();
        check("mid_busy", 128'(bus.busy), 128'(1));
        resetN = 1'b0;
        #1;
        model_clear();
        check("mrst_busy", 128'(bus.busy), 128'(0));
        check("mrst_valid", 128'(bus.slotValid), 128'(0));
        check("mrst_locked", 128'(bus.locked), 128'(0));
        check("mrst_rd_valid", 128'(bus.rdValid), 128'(0));
        check_flat("mrst_flat");
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        check("mrst_wr_ready", 128'(bus.wrReady), 128'(1));
        check("mrst_idle", 128'(bus.busy), 128'(0));
        wr(3, 7, 32'hCAFEF00D);
        rd(3, 7, "rd_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
